// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared defaults for the switch debouncer.
//   SW_WIDTH_DEFAULT            number of switch inputs
//   SW_DEBOUNCE_CYCLES_DEFAULT  stable clocks needed to accept a new level
//   SW_CLK_HZ                   nominal clk frequency the default assumes
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

    localparam int SW_WIDTH_DEFAULT           = 8;
    localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;   // 10 ms at 50 MHz
    localparam int SW_CLK_HZ                  = 50000000;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch input: 2-flop synchronizer, stability counter and the
// registered clean level / one-cycle change pulse.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   sw_raw      asynchronous, bouncing switch level
//   sw_clean    debounced level (registered)
//   sw_changed  one-cycle pulse when sw_clean changes (registered)
// ---------------------------------------------------------------------------
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q,   sync1_d;
    logic             sync2_q,   sync2_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             clean_q,   clean_d;
    logic             changed_q, changed_d;

    always_comb begin
        sync1_d   = sw_raw;
        sync2_d   = sync1_q;
        cnt_d     = '0;
        clean_d   = clean_q;
        changed_d = 1'b0;

        // Any cycle matching the accepted level restarts the count, so a
        // single bounce throws away all progress.
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                clean_d   = sync2_q;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            clean_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            changed_q <= changed_d;
        end
    end

    assign sw_clean   = clean_q;
    assign sw_changed = changed_q;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Debounces WIDTH switch inputs independently and optionally keeps sticky
// per-bit change flags for the switch peripheral.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   sw_raw        asynchronous, bouncing switch levels
//   sw_clean      debounced levels (registered)
//   sw_changed    one-cycle pulse per bit when sw_clean changes
//   edge_clear    per-bit clear for edge_capture
//   edge_capture  sticky per-bit change flags
//
// Build option
//   SW_DEBOUNCE_EDGE_CAPTURE_EN  when defined, edge_capture is live; when
//                                undefined it reads 0 and edge_clear is
//                                ignored.
// ---------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw_raw[i]),
            .sw_clean   (sw_clean[i]),
            .sw_changed (sw_changed[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;

    // Set wins over a simultaneous clear so a change is never lost.
    always_comb begin
        edge_capture_d = (edge_capture_q & ~edge_clear) | sw_changed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture_q <= '0;
        end else begin
            edge_capture_q <= edge_capture_d;
        end
    end

    assign edge_capture = edge_capture_q;
`else
    logic edge_clear_unused;

    assign edge_clear_unused = ^edge_clear;
    assign edge_capture      = '0;
`endif

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
// Bench for sw_debounce with WIDTH=8, DEBOUNCE_CYCLES=4. A history-based
// model decides each clean-level change from the last N synchronized samples
// and is compared with the DUT on every falling edge; directed scenarios add
// literal expectations at the key clocks.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic [W-1:0] edge_clear;
    logic [W-1:0] edge_capture;

    int vectors     = 0;
    int miscompares = 0;

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .sw_clean     (sw_clean),
        .sw_changed   (sw_changed),
        .edge_clear   (edge_clear),
        .edge_capture (edge_capture)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // hist[t] is sw_raw as sampled on edge t; a bit flips on edge t when the
    // synchronized level (two edges late) has disagreed with the accepted
    // level on each of the last N edges, none of them a reset edge nor at or
    // before that bit's previous flip.
    logic [W-1:0] hist     [MAXE];
    logic         rst_hist [MAXE];
    int           t          = 0;
    int           last_reset = 0;
    int           last_flip  [W];
    bit           valid      = 1'b0;
    logic [W-1:0] exp_clean, exp_changed, exp_ec, ec_next, flip;
    bit           ok;
    int           e;

    function automatic logic sync_level(int k, int b);
        if (rst_hist[k] || rst_hist[k+1]) return 1'b0;
        return hist[k][b];
    endfunction

    initial begin
        for (int b = 0; b < W; b++) last_flip[b] = 0;
    end

    always @(posedge clk) begin
        if (t < MAXE - 2) t = t + 1;
        hist[t]     = sw_raw;
        rst_hist[t] = reset;
        if (reset) begin
            exp_clean   = '0;
            exp_changed = '0;
            exp_ec      = '0;
            last_reset  = t;
            valid       = 1'b1;
        end else if (valid) begin
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
            ec_next = exp_changed | (exp_ec & ~edge_clear);
`else
            ec_next = '0;
`endif
            flip = '0;
            for (int b = 0; b < W; b++) begin
                ok = 1'b1;
                for (int j = 0; j < N; j++) begin
                    e = t - j;
                    if (e <= last_reset || e <= last_flip[b]) ok = 1'b0;
                    else if (sync_level(e - 2, b) == exp_clean[b]) ok = 1'b0;
                end
                if (ok) begin
                    flip[b]      = 1'b1;
                    last_flip[b] = t;
                end
            end
            exp_clean   = exp_clean ^ flip;
            exp_changed = flip;
            exp_ec      = ec_next;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("sw_clean",     sw_clean,     exp_clean);
            check("sw_changed",   sw_changed,   exp_changed);
            check("edge_capture", edge_capture, exp_ec);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sw_raw = '0;
        reset  = 1'b1;
        step(2);
        reset  = 1'b0;
        step(2);
    endtask

    logic [W-1:0] ec_exp_lit;

    initial begin
        reset      = 1'b1;
        sw_raw     = 8'hFF;
        edge_clear = '0;

        // reset held 3 clocks with switches high, then release
        step(3);
        check("rst_clean_lit", sw_clean, 8'h00);
        check("rst_ec_lit",    edge_capture, 8'h00);
        reset = 1'b0;
        step(5);
        check("rel5_clean_lit", sw_clean, 8'h00);
        step(1);
        check("rel6_clean_lit",   sw_clean,   8'hFF);
        check("rel6_changed_lit", sw_changed, 8'hFF);
        check("rel6_model_lit",   exp_clean,  8'hFF);

        // clean step on bit 0
        do_reset();
        sw_raw = 8'h01;
        step(5);
        check("step5_clean_lit", sw_clean, 8'h00);
        step(1);
        check("step6_clean_lit",   sw_clean,    8'h01);
        check("step6_changed_lit", sw_changed,  8'h01);
        check("step6_model_lit",   exp_changed, 8'h01);
        step(1);
        check("step7_changed_lit", sw_changed, 8'h00);
        check("step7_clean_lit",   sw_clean,   8'h01);

        // bounce on bit 3: 1,0,1,0 then hold 1
        do_reset();
        sw_raw = 8'h08; step(1);
        sw_raw = 8'h00; step(1);
        sw_raw = 8'h08; step(1);
        sw_raw = 8'h00; step(1);
        sw_raw = 8'h08;
        step(5);
        check("bnc5_clean_lit", sw_clean, 8'h00);
        step(1);
        check("bnc6_clean_lit",   sw_clean,   8'h08);
        check("bnc6_changed_lit", sw_changed, 8'h08);
        step(1);
        check("bnc7_changed_lit", sw_changed, 8'h00);

        // reset in the middle of a count on bit 7
        do_reset();
        sw_raw = 8'h80;
        step(3);
        reset = 1'b1;
        step(2);
        check("mid_rst_clean_lit", sw_clean, 8'h00);
        reset = 1'b0;
        step(5);
        check("mid5_clean_lit", sw_clean, 8'h00);
        step(1);
        check("mid6_clean_lit",   sw_clean,   8'h80);
        check("mid6_changed_lit", sw_changed, 8'h80);

        // several bits at once, up then back down
        do_reset();
        sw_raw = 8'hA5;
        step(5);
        check("multi5_clean_lit", sw_clean, 8'h00);
        step(1);
        check("multi6_clean_lit",   sw_clean,   8'hA5);
        check("multi6_changed_lit", sw_changed, 8'hA5);
        sw_raw = 8'h00;
        step(6);
        check("fall6_clean_lit",   sw_clean,   8'h00);
        check("fall6_changed_lit", sw_changed, 8'hA5);

        // edge capture: clear coincident with the change pulse, then lone clear
        do_reset();
`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
        ec_exp_lit = 8'h04;
`else
        ec_exp_lit = 8'h00;
`endif
        sw_raw = 8'h04;
        step(6);
        check("ec_changed_lit", sw_changed, 8'h04);
        edge_clear = 8'h04;
        step(1);
        edge_clear = 8'h00;
        check("ec_set_wins_lit", edge_capture, ec_exp_lit);
        step(2);
        check("ec_sticky_lit", edge_capture, ec_exp_lit);
        edge_clear = 8'h04;
        step(1);
        edge_clear = 8'h00;
        check("ec_cleared_lit", edge_capture, 8'h00);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sw_debounce

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of switch inputs debounced.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clocks needed to accept a new level (10 ms at 50 MHz); legal range is 2 or more.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port sw_raw, input, WIDTH: asynchronous, bouncing switch levels from the board pins.
REQ-006 Port sw_clean, output, WIDTH: debounced levels, driving the PIO input port of the switch peripheral.
REQ-007 Port sw_changed, output, WIDTH: one-clock pulse per bit when that bit's sw_clean value changes.
REQ-008 Port edge_clear, input, WIDTH: per-bit clear for edge_capture.
REQ-009 Port edge_capture, output, WIDTH: sticky per-bit change flags.

Function
REQ-010 Each sw_raw bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-011 Each bit SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES).
REQ-012 On any clock where sync2 equals sw_clean, that bit's counter SHALL load 0.
REQ-013 On any clock where sync2 differs from sw_clean and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 On any clock where sync2 differs from sw_clean and the counter equals DEBOUNCE_CYCLES-1, the block SHALL:
 - set sw_clean to sync2;
 - load the counter with 0;
 - drive sw_changed high for exactly that one registered cycle.
REQ-015 Latency: a clean raw step SHALL appear on sw_clean DEBOUNCE_CYCLES+2 clocks after the first clk edge that samples the new level.
REQ-016 A bounce, meaning any single cycle where sync2 returns to the sw_clean value, SHALL restart the count from 0; no partial credit is kept.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1, and it SHALL never wrap.
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each be handled per REQ-012..014 in the same cycle.
REQ-019 sw_clean and sw_changed SHALL be registered outputs with no combinational path from any input.

Reset
REQ-020 When reset is high at a clk edge, the block SHALL clear all of the following to 0:
 - sync1 and sync2;
 - sw_clean;
 - all counters;
 - sw_changed;
 - edge_capture.
REQ-021 Reset SHALL take priority over all other activity, including a debounce in progress, which is abandoned.
REQ-022 If sw_raw bits are held at 1 through reset, the corresponding sw_clean bits SHALL rise DEBOUNCE_CYCLES+2 clocks after reset deasserts, with a sw_changed pulse.

Configuration
REQ-023 Macro SW_DEBOUNCE_EDGE_CAPTURE_EN SHALL enable the edge-capture logic.
REQ-024 With the macro defined:
 - edge_capture[i] SHALL be set on the clock after sw_changed[i] is high;
 - edge_capture[i] SHALL be cleared on the clock after edge_clear[i] is high;
 - if set and clear occur in the same cycle, set SHALL win.
REQ-025 With the macro undefined, the edge_capture and edge_clear ports SHALL still exist, edge_capture SHALL be constant 0, and edge_clear SHALL be ignored.

Structure
REQ-026 Package sw_debounce_pkg SHALL hold:
 - SW_WIDTH_DEFAULT = 8;
 - SW_DEBOUNCE_CYCLES_DEFAULT = 500000;
 - SW_CLK_HZ = 50000000.
REQ-027 Sub-module sw_debounce_bit SHALL implement one bit (synchronizer, counter, clean/changed registers) and SHALL be instantiated WIDTH times by a generate loop; edge-capture logic SHALL live in the top level.

Verification
(All scenarios use DEBOUNCE_CYCLES=4, WIDTH=8.)
REQ-028 Reset check: hold reset for 3 clocks with sw_raw=8'hFF -> sw_clean=8'h00, sw_changed=0 and edge_capture=0 throughout reset; sw_clean=8'hFF at the 6th clock after release.
REQ-029 Clean step: sw_raw 8'h00 -> 8'h01 held -> sw_clean[0] rises 6 clocks after the sampling edge, sw_changed[0] pulses exactly 1 cycle, other bits stay unchanged.
REQ-030 Bounce: sw_raw[3] toggles 1,0,1,0 on alternate clocks, then holds 1 -> no change until 6 clocks after the final rise, then exactly one sw_changed[3] pulse.
REQ-031 Reset mid-count: sw_raw=8'h80, assert reset after 3 clocks -> sw_clean[7] stays 0; after release it rises 6 clocks later.
REQ-032 Multi-bit: sw_raw 8'h00 -> 8'hA5 in one cycle -> sw_clean=8'hA5 and sw_changed=8'hA5 in the same cycle.
REQ-033 Edge capture, macro defined: bit 2 changes while edge_clear[2] is pulsed in the sw_changed[2] cycle -> edge_capture[2]=1 next clock; a later lone edge_clear[2] clears it. With the macro undefined, edge_capture stays 8'h00.
